video_timing_generator: RTL and testbench

// Raster timing and test-pattern source feeding the three TMDS encoder/serializer channels.

---
 rtl/video_timing_generator.sv | 90 +++++++++
 tb/tb_video_timing_generator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_generator.sv
// video_timing_generator: raster counters, syncs and test patterns for the TMDS encoders.
// All outputs share one register stage, so they describe the position held in the previous cycle.
module video_timing_generator #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FRONT  = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FRONT  = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 20,
    parameter int SYNC_POL = 1
) (
    input  logic        pixelClock,
    input  logic        resetN,
    input  logic [1:0]  patternSelect,
    input  logic [23:0] solidColour,
    output logic        DE,
    output logic [1:0]  controlBus,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frameStart
);
    localparam logic [11:0] HA       = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [11:0] VA       = 12'(V_ACTIVE);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
    localparam logic        POL      = 1'(SYNC_POL);

    logic [11:0] h_count, v_count, bar_count;
    logic [2:0]  bar_index;
    logic [1:0]  pattern, pattern_now;
    logic [23:0] solid, solid_now, bar_rgb, pixel_rgb;
    logic        origin, active, hsync, vsync, h_wrap, v_wrap, bar_end;

    // Pattern and colour are taken straight from the inputs at (0,0) so the new frame uses them from its first pixel.
    always_comb begin
        origin      = h_count == '0 && v_count == '0;
        active      = h_count < HA && v_count < VA;
        hsync       = h_count >= HS_START && h_count < HS_END;
        vsync       = v_count >= VS_START && v_count < VS_END;
        h_wrap      = h_count == H_LAST;
        v_wrap      = v_count == V_LAST;
        bar_end     = bar_count == BAR_LAST;
        pattern_now = origin ? patternSelect : pattern;
        solid_now   = origin ? solidColour : solid;
        bar_rgb     = {{8{~bar_index[1]}}, {8{~bar_index[2]}}, {8{~bar_index[0]}}};
        pixel_rgb   = pattern_now == 2'b00 ? bar_rgb :
                      pattern_now == 2'b01 ? solid_now :
                      pattern_now == 2'b10 ? {3{h_count[7:0]}} :
                      {24{~(h_count[5] ^ v_count[5])}};
    end

    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            h_count    <= '0;
            v_count    <= '0;
            bar_count  <= '0;
            bar_index  <= '0;
            pattern    <= 2'b00;
            solid      <= '0;
            DE         <= 1'b0;
            frameStart <= 1'b0;
            controlBus <= {2{~POL}};
            red        <= '0;
            green      <= '0;
            blue       <= '0;
        end else begin
            h_count    <= h_wrap ? '0 : h_count + 12'd1;
            if (h_wrap)
                v_count <= v_wrap ? '0 : v_count + 12'd1;
            bar_count  <= (h_wrap || bar_end) ? '0 : bar_count + 12'd1;
            bar_index  <= h_wrap ? '0 : bar_end ? bar_index + 3'd1 : bar_index;
            if (origin) begin
                pattern <= patternSelect;
                solid   <= solidColour;
            end
            DE         <= active;
            frameStart <= origin;
            controlBus <= POL ? {vsync, hsync} : ~{vsync, hsync};
            {red, green, blue} <= active ? pixel_rgb : 24'h0;
        end
    end
endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator: reduced-raster bench with a per-cycle reference scoreboard,
// table-driven bar and pattern vectors, and hand sequences for sync, frame and reset corners.
module tb_video_timing_generator;
    localparam int HA = 264, HF = 4, HS = 4, HB = 8;
    localparam int VA = 33, VF = 1, VS = 2, VB = 1, POL = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct {
        int          pix;
        logic [23:0] rgb;
    } bar_vec_t;

    typedef struct {
        logic [1:0]  ps;
        logic [23:0] sc;
        logic [23:0] px0;
        int          pix;
        logic [23:0] rgb;
    } pat_vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  psel = 2'b00;
    logic [23:0] solid = 24'h0;
    logic        de, fs;
    logic [1:0]  cb;
    logic [7:0]  r, g, b;
    int          checks = 0, errors = 0;
    logic [27:0] sbq[$];
    logic [23:0] bars[8];

    always #5 clk = ~clk;

    video_timing_generator #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POL)
    ) dut (
        .pixelClock(clk),
        .resetN(rst_n),
        .patternSelect(psel),
        .solidColour(solid),
        .DE(de),
        .controlBus(cb),
        .red(r),
        .green(g),
        .blue(b),
        .frameStart(fs)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs && n < FT + 8);
        chk("frame_start_seen", fs, 1'b1);
    endtask

    // Reference model: pushes the outputs each edge should produce
    initial begin
        int mh, mv;
        logic [1:0]  lps;
        logic [23:0] lsc, rgb;
        logic act, hs, vs, efs;
        logic [1:0] ecb;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        mh = 0; mv = 0; lps = 2'b00; lsc = 24'h0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mh = 0; mv = 0; lps = 2'b00;
                sbq.push_back({1'b0, (POL != 0) ? 2'b00 : 2'b11, 24'h0, 1'b0});
            end else begin
                efs = (mh == 0 && mv == 0);
                if (efs) begin
                    lps = psel;
                    lsc = solid;
                end
                act = (mh < HA) && (mv < VA);
                hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
                vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
                ecb = (POL != 0) ? {vs, hs} : {!vs, !hs};
                case (lps)
                    2'd0:    rgb = bars[mh / (HA / 8)];
                    2'd1:    rgb = lsc;
                    2'd2:    rgb = {3{8'(mh % 256)}};
                    default: rgb = ((((mh / 32) ^ (mv / 32)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
                endcase
                if (!act) rgb = 24'h0;
                sbq.push_back({act, ecb, rgb, efs});
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv++;
                    if (mv == VT) mv = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) chk("scoreboard", {de, cb, r, g, b, fs}, sbq.pop_front());
        end
    end

    initial begin
        bar_vec_t bv[11];
        pat_vec_t pv[4];
        logic [23:0] line_rgb[HT];
        logic [23:0] late_bar;
        int de_line, de_low, hs_first, hs_cnt, de_cnt, fs_cnt, vs_first, vs_cnt;
        bv = '{'{0, 24'hFFFFFF}, '{32, 24'hFFFFFF}, '{33, 24'hFFFF00}, '{66, 24'h00FFFF},
               '{99, 24'h00FF00}, '{132, 24'hFF00FF}, '{165, 24'hFF0000}, '{198, 24'h0000FF},
               '{231, 24'h000000}, '{263, 24'h000000}, '{264, 24'h000000}};
        pv = '{'{2'b10, 24'h000000, 24'h000000, 260, 24'h040404},
               '{2'b11, 24'h000000, 24'hFFFFFF, 32, 24'h000000},
               '{2'b01, 24'hABCDEF, 24'hABCDEF, 200, 24'hABCDEF},
               '{2'b00, 24'h000000, 24'hFFFFFF, 33, 24'hFFFF00}};
        de_line = 0; de_low = 0; hs_first = -1; hs_cnt = 0;
        de_cnt = 0; fs_cnt = 0; vs_first = -1; vs_cnt = 0; late_bar = 24'h0;

        repeat (3) @(negedge clk);
        chk("reset_de", de, 1'b0);
        chk("reset_fs", fs, 1'b0);
        chk("reset_rgb", {r, g, b}, 24'h0);
        chk("reset_sync", cb, (POL != 0) ? 2'b00 : 2'b11);

        rst_n = 1'b1;
        @(negedge clk);
        chk("release_de", de, 1'b1);
        chk("release_fs", fs, 1'b1);
        chk("release_px0", {r, g, b}, 24'hFFFFFF);

        for (int i = 0; i <= FT; i++) begin
            if (i > 0) @(negedge clk);
            if (i < HT) begin
                line_rgb[i] = {r, g, b};
                if (de) de_line++; else de_low++;
                if (cb[0]) begin
                    if (hs_first < 0) hs_first = i;
                    hs_cnt++;
                end
            end
            if (i < FT) begin
                if (de) de_cnt++;
                if (fs) fs_cnt++;
                if (cb[1]) begin
                    if (vs_first < 0) vs_first = i;
                    vs_cnt++;
                end
            end
            if (i == (VA - 1) * HT + 40) late_bar = {r, g, b};
            if (i == FT / 2) begin
                psel = 2'b01;
                solid = 24'h123456;
            end
        end
        chk("next_frame_fs", fs, 1'b1);
        chk("next_frame_solid_px0", {r, g, b}, 24'h123456);
        chk("line_de_high", de_line, HA);
        chk("line_de_low", de_low, HT - HA);
        chk("hsync_offset", hs_first, HA + HF);
        chk("hsync_width", hs_cnt, HS);
        chk("frame_de_count", de_cnt, VA * HA);
        chk("frame_fs_count", fs_cnt, 1);
        chk("vsync_start", vs_first, (VA + VF) * HT);
        chk("vsync_width", vs_cnt, VS * HT);
        chk("bars_hold_after_change", late_bar, 24'hFFFF00);
        for (int k = 0; k < 11; k++)
            chk($sformatf("bar_px%0d", bv[k].pix), line_rgb[bv[k].pix], bv[k].rgb);

        for (int k = 0; k < 4; k++) begin
            psel = pv[k].ps;
            solid = pv[k].sc;
            wait_fs();
            chk($sformatf("pattern%0d_px0", k), {r, g, b}, pv[k].px0);
            repeat (pv[k].pix) @(negedge clk);
            chk($sformatf("pattern%0d_px%0d", k, pv[k].pix), {r, g, b}, pv[k].rgb);
        end

        repeat ((VA + VF) * HT + HA + HF + 1 - pv[3].pix) @(negedge clk);
        chk("pre_reset_syncs", cb, (POL != 0) ? 2'b11 : 2'b00);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midframe_reset_de", de, 1'b0);
        chk("midframe_reset_fs", fs, 1'b0);
        chk("midframe_reset_rgb", {r, g, b}, 24'h0);
        chk("midframe_reset_sync", cb, (POL != 0) ? 2'b00 : 2'b11);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerelease_de", de, 1'b1);
        chk("rerelease_fs", fs, 1'b1);
        chk("rerelease_px0", {r, g, b}, 24'hFFFFFF);
        chk("rerelease_sync", cb, (POL != 0) ? 2'b00 : 2'b11);
        repeat (HT + 5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
